seven_segment_scan_driver: RTL

Multiplexed 4-digit seven-segment display driver. It sits directly downstream of the Nios system's 4-bit seven-segment PIO output. Each rising edge on `load` shifts the current 4-bit hex value into a digit history buffer. The block then time-multiplexes the buffered digits onto shared segment lines, with hex decode, leading-digit blanking and anti-ghosting dead time.

---
 rtl/seven_segment_scan_driver_if.sv | 31 +++
 rtl/seven_segment_scan_driver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_scan_driver_if
//  Purpose  : Digit-load controls and multiplexed display outputs of the
//             seven-segment scan driver, bundled with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [3:0]            digit_in;
  logic                  load;
  logic                  clear;
  logic                  blank_leading;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] digit_en;

  // Master drives the digit stream and controls, and observes the display.
  modport master (
    output digit_in, load, clear, blank_leading,
    input  seg, dp, digit_en
  );

  // Slave is the driver itself.
  modport slave (
    input  digit_in, load, clear, blank_leading,
    output seg, dp, digit_en
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_scan_driver
//  Purpose  : Multiplexed seven-segment driver. Rising edges on load shift a
//             hex digit into a history buffer; buffered digits are scanned
//             onto shared segment lines with hex decode, leading blanking and
//             one dead cycle per digit slot to prevent ghosting.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 12500,
  parameter int COMMON_ANODE = 1
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  seven_segment_scan_driver_if.slave bus
);

  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int c_RC_W  = $clog2(REFRESH_DIV);

  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(NUM_DIGITS);
  localparam logic [c_RC_W-1:0]  c_RCNT_LAST = c_RC_W'(REFRESH_DIV - 1);

  // Active-low polarity is applied by XOR with this bit on every output.
  localparam logic c_INV = (COMMON_ANODE != 0);

  // Hex digit to active-high segment pattern (bit0 = a .. bit6 = g).
  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  logic                       r_load_q;
  logic [NUM_DIGITS-1:0][3:0] r_buf;
  logic [c_CNT_W-1:0]         r_cnt;
  logic [c_RC_W-1:0]          r_rcnt;
  logic [c_IDX_W-1:0]         r_idx;
  logic [6:0]                 r_seg;
  logic [NUM_DIGITS-1:0]      r_en;
  logic                       r_dp;

  logic                       w_shift;
  logic                       w_slot_end;
  logic                       w_blank;
  logic [6:0]                 w_pat;
  logic [NUM_DIGITS-1:0]      w_en;

  assign w_shift    = bus.load & ~r_load_q;
  assign w_slot_end = (r_rcnt == c_RCNT_LAST);

  // Load strobe edge detector: remembers last cycle's load level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_load_q <= 1'b0;
    else       r_load_q <= bus.load;
  end

  // Digit history buffer and valid-slot count; clear wins over a shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (bus.clear) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (w_shift) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        r_buf[i] <= r_buf[i-1];
      end
      r_buf[0] <= bus.digit_in;
      if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Refresh timer and scan index; index steps at the end of each slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rcnt <= '0;
      r_idx  <= '0;
    end else if (w_slot_end) begin
      r_rcnt <= '0;
      r_idx  <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
    end else begin
      r_rcnt <= r_rcnt + c_RC_W'(1);
    end
  end

  // Segment pattern of the slot under scan, blanked when not yet filled.
  always_comb begin
    w_blank = bus.blank_leading && (c_CNT_W'(r_idx) >= r_cnt);
    w_pat   = w_blank ? 7'h00 : f_hex7(r_buf[r_idx]);
  end

  // One-hot enable for the scanned slot, dark on the last cycle of a slot.
  always_comb begin
    w_en = '0;
    if (!w_slot_end) w_en[r_idx] = 1'b1;
  end

  // Registered, polarity-adjusted display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= {7{c_INV}};
      r_en  <= {NUM_DIGITS{c_INV}};
      r_dp  <= c_INV;
    end else begin
      r_seg <= w_pat ^ {7{c_INV}};
      r_en  <= w_en ^ {NUM_DIGITS{c_INV}};
      r_dp  <= c_INV;
    end
  end

  assign bus.seg      = r_seg;
  assign bus.digit_en = r_en;
  assign bus.dp       = r_dp;

endmodule
`default_nettype wire
